mem_acc_rmw: RTL

- Multi-layer, NUM_PE-wide accumulation memory with its own read-modify-write datapath: accepts partial sums and adds them into stored values.
- Includes hazard forwarding for back-to-back same-address updates, optional saturation with sticky overflow flags, a layer-clear engine and a separate read-out port.
- Sits between the PE array and the activation/output stage; replaces the plain write/read accumulation buffer.

---
 rtl/mem_acc_pkg.sv | 21 ++
 rtl/bram_sdp.sv | 24 ++
 rtl/sat_add.sv | 27 ++
 rtl/mem_acc_rmw.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mem_acc_pkg.sv
// Shared types and constants for the read-modify-write accumulation memory.
package mem_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_e;

    localparam logic ACC_MODE_LOAD = 1'b0;
    localparam logic ACC_MODE_ACC  = 1'b1;

    localparam int STAGE_VALID_BW = 1;
    localparam int STAGE_MODE_BW  = 1;

    // Full BRAM address = {layer, address within layer}.
    function automatic int full_addr_bw(input int layer_bw, input int sl_bw);
        return layer_bw + sl_bw;
    endfunction

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port block RAM: one write port, one registered read-first read port.
module bram_sdp #(
    parameter int DW = 32,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // NOTE: the array and its read register have no reset; a RAM cannot be
    // reset in one cycle, so contents are defined by a layer clear instead.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sat_add.sv
// Sign-extending adder with signed saturation or wrap plus overflow detection.
module sat_add #(
    parameter int IN_BW    = 24,
    parameter int ACC_BW   = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic [ACC_BW-1:0] a,
    input  logic [IN_BW-1:0]  b,
    output logic [ACC_BW-1:0] sum,
    output logic              ovf
);

    logic [ACC_BW:0] wide;

    // NOTE: every output of a combinational block is assigned before any
    // condition so that no path leaves it unassigned and infers a latch.
    always_comb begin
        wide = {a[ACC_BW-1], a} + {{(ACC_BW + 1 - IN_BW){b[IN_BW-1]}}, b};
        ovf  = wide[ACC_BW] != wide[ACC_BW-1];
        sum  = wide[ACC_BW-1:0];
        if (SATURATE && ovf) begin
            sum = wide[ACC_BW] ? {1'b1, {(ACC_BW - 1){1'b0}}}
                               : {1'b0, {(ACC_BW - 1){1'b1}}};
        end
    end

endmodule

// File: rtl/mem_acc_rmw.sv
// Multi-layer accumulation memory: pipelined read-modify-write with hazard
// forwarding, sticky overflow flags, a layer-clear engine and a read-out port.
module mem_acc_rmw
    import mem_acc_pkg::*;
#(
    parameter int NUM_PE              = 16,
    parameter int ACC_BW              = 32,
    parameter int IN_BW               = 24,
    parameter int NUM_LAYER_BW        = 2,
    parameter int MEM_ACC_DEPTH_SL_BW = 7,
    parameter bit SATURATE            = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           acc_valid,
    output logic                           acc_ready,
    input  logic                           acc_mode,
    input  logic [NUM_LAYER_BW-1:0]        acc_layer,
    input  logic [MEM_ACC_DEPTH_SL_BW-1:0] acc_addr,
    input  logic [NUM_PE*IN_BW-1:0]        acc_din,
    input  logic                           rd_valid,
    output logic                           rd_ready,
    input  logic [NUM_LAYER_BW-1:0]        rd_layer,
    input  logic [MEM_ACC_DEPTH_SL_BW-1:0] rd_addr,
    output logic                           dout_valid,
    output logic [NUM_PE*ACC_BW-1:0]       dout,
    input  logic                           clr_req,
    input  logic [NUM_LAYER_BW-1:0]        clr_layer,
    output logic                           clr_busy,
    output logic [NUM_PE-1:0]              ovf_flag
);

    localparam int AW = full_addr_bw(NUM_LAYER_BW, MEM_ACC_DEPTH_SL_BW);

    typedef struct packed {
        logic [STAGE_VALID_BW-1:0] valid;
        logic [STAGE_MODE_BW-1:0]  mode;
        logic [AW-1:0]             addr;
    } stage_t;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
    } wb_t;

    state_e state, state_nxt;
    logic   alive, acc_fire, rd_fire, clr_fire, clr_we, rd_pending;
    logic [NUM_LAYER_BW-1:0]        clr_layer_q;
    logic [MEM_ACC_DEPTH_SL_BW-1:0] cnt;
    stage_t s1;
    wb_t    s2, s3;

    logic [NUM_PE-1:0][IN_BW-1:0]  s1_din;
    logic [NUM_PE-1:0][ACC_BW-1:0] s2_data, s3_data, bram_q, dout_hold, sum, wr_data;
    logic [NUM_PE-1:0]             sum_ovf;
    logic [AW-1:0]                 bram_raddr, wr_addr;
    logic                          bram_re, wr_en;

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (clr_fire) state_nxt = DRAIN;
            DRAIN:   if (!s1.valid && !s2.valid) state_nxt = CLEAR;
            CLEAR:   if (cnt == '1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // alive keeps both handshakes low for the first cycle after reset release.
    always_comb begin
        acc_ready = alive && (state == IDLE) && !clr_req;
        rd_ready  = alive && (state == IDLE) && !acc_valid && !s1.valid && !s2.valid;
        clr_busy  = state != IDLE;
        clr_we    = state == CLEAR;
    end

    assign acc_fire   = acc_valid && acc_ready;
    assign rd_fire    = rd_valid && rd_ready;
    assign clr_fire   = alive && (state == IDLE) && clr_req;
    assign bram_re    = acc_fire || rd_fire;
    assign bram_raddr = acc_fire ? {acc_layer, acc_addr} : {rd_layer, rd_addr};
    assign wr_en      = clr_we || s2.valid;
    assign wr_addr    = clr_we ? {clr_layer_q, cnt} : s2.addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive       <= 1'b0;
            s1          <= '0;
            s2          <= '0;
            s3          <= '0;
            rd_pending  <= 1'b0;
            dout_hold   <= '0;
            ovf_flag    <= '0;
            clr_layer_q <= '0;
            cnt         <= '0;
        end else begin
            alive      <= 1'b1;
            s1         <= '{valid: acc_fire, mode: acc_mode, addr: {acc_layer, acc_addr}};
            s2         <= '{valid: s1.valid, addr: s1.addr};
            // Entering CLEAR drops the last-write record so stale data is never forwarded.
            s3         <= (state == DRAIN && state_nxt == CLEAR) ? '0 : s2;
            rd_pending <= rd_fire;
            if (rd_pending) dout_hold <= bram_q;
            if (clr_fire)      ovf_flag <= '0;
            else if (s1.valid) ovf_flag <= ovf_flag | sum_ovf;
            if (clr_fire) clr_layer_q <= clr_layer;
            cnt <= clr_we ? cnt + 1'b1 : '0;
        end
    end

    // Payload registers are qualified by the valid bits above.
    always_ff @(posedge clk) begin
        s1_din  <= acc_din;
        s2_data <= sum;
        s3_data <= s2_data;
    end

    assign dout_valid = rd_pending;
    assign dout       = rd_pending ? bram_q : dout_hold;

    for (genvar pe = 0; pe < NUM_PE; pe++) begin : g_pe
        logic [ACC_BW-1:0] operand;

        // Newest in-flight value for the same address wins over the RAM.
        always_comb begin
            if (s1.mode == ACC_MODE_LOAD)                 operand = '0;
            else if (s2.valid && s2.addr == s1.addr)      operand = s2_data[pe];
            else if (s3.valid && s3.addr == s1.addr)      operand = s3_data[pe];
            else                                          operand = bram_q[pe];
        end

        sat_add #(
            .IN_BW   (IN_BW),
            .ACC_BW  (ACC_BW),
            .SATURATE(SATURATE)
        ) u_sat_add (
            .a  (operand),
            .b  (s1_din[pe]),
            .sum(sum[pe]),
            .ovf(sum_ovf[pe])
        );

        assign wr_data[pe] = clr_we ? '0 : s2_data[pe];

        bram_sdp #(
            .DW(ACC_BW),
            .AW(AW)
        ) u_bram (
            .clk  (clk),
            .we   (wr_en),
            .waddr(wr_addr),
            .wdata(wr_data[pe]),
            .re   (bram_re),
            .raddr(bram_raddr),
            .rdata(bram_q[pe])
        );
    end

endmodule
